// File: rtl/pipe_ctrl.sv
// pipe_ctrl: one-hot multi-cycle pipeline sequencer for the RISC-V core.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_en,
    input  logic [4:0]  I_aluop,
    input  logic        I_memop,
    input  logic        I_shldbranch,
    input  logic        I_mem_ready,
    input  logic        I_halt,
    output logic [6:0]  o_state,
    output logic        o_fetch_en,
    output logic        o_decode_en,
    output logic        o_regread_en,
    output logic        o_alu_en,
    output logic        o_mem_en,
    output logic        o_regwrite_en,
    output logic        o_pc_inc,
    output logic        o_pc_load,
    output logic [15:0] o_cyc_count,
    output logic [15:0] o_instr_count
);

    localparam logic [6:0] S_RESET   = 7'b000_0001;
    localparam logic [6:0] S_FETCH   = 7'b000_0010;
    localparam logic [6:0] S_DECODE  = 7'b000_0100;
    localparam logic [6:0] S_REGREAD = 7'b000_1000;
    localparam logic [6:0] S_EXEC    = 7'b001_0000;
    localparam logic [6:0] S_MEM     = 7'b010_0000;
    localparam logic [6:0] S_WB      = 7'b100_0000;
    localparam logic [6:0] S_HALT    = 7'b000_0000;

    localparam logic [3:0] OP_JMPA = 4'd12;
    localparam logic [3:0] OP_JMPR = 4'd13;

    logic [6:0] state_q;
    logic [6:0] state_d;
    logic       branch_q;
    logic       br_op_q;
    logic       is_br_op;
    logic       in_wb;

    // The signed/variant bit plays no part in sequencing.
    logic unused_aluop_variant;
    assign unused_aluop_variant = I_aluop[0];

    assign is_br_op = (I_aluop[4:1] == OP_JMPA) || (I_aluop[4:1] == OP_JMPR);
    assign in_wb    = state_q[6];

    // Next-state selection; HALT (all-zero) falls to the default and holds.
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            state_q[0]: state_d = S_FETCH;
            state_q[1]: if (I_mem_ready) state_d = S_DECODE;
            state_q[2]: state_d = S_REGREAD;
            state_q[3]: state_d = S_EXEC;
            state_q[4]: state_d = I_memop ? S_MEM : S_WB;
            state_q[5]: if (I_mem_ready) state_d = S_WB;
            state_q[6]: state_d = I_halt ? S_HALT : S_FETCH;
            default:    state_d = state_q;
        endcase
    end

    // State register; a stall (I_en=0) freezes it.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= S_RESET;
        end else if (I_en) begin
            state_q <= state_d;
        end
    end

    // Capture branch outcome and branch-op class when leaving EXEC.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            branch_q <= 1'b0;
            br_op_q  <= 1'b0;
        end else if (I_en && state_q[4]) begin
            branch_q <= I_shldbranch;
            br_op_q  <= is_br_op;
        end
    end

    assign o_state       = state_q;
    assign o_fetch_en    = I_en & state_q[1];
    assign o_decode_en   = I_en & state_q[2];
    assign o_regread_en  = I_en & state_q[3];
    assign o_alu_en      = I_en & state_q[4];
    assign o_mem_en      = I_en & (state_q[1] | state_q[5]);
    assign o_regwrite_en = I_en & in_wb & ~br_op_q;
    assign o_pc_load     = I_en & in_wb & branch_q;
    assign o_pc_inc      = I_en & in_wb & ~branch_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] cyc_q;
    logic [15:0] instr_q;

    // Cycle count covers active states; instruction count ticks on WB exit.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            cyc_q   <= 16'h0000;
            instr_q <= 16'h0000;
        end else if (I_en) begin
            if (|state_q[6:1]) cyc_q <= cyc_q + 16'd1;
            if (in_wb) instr_q <= instr_q + 16'd1;
        end
    end

    assign o_cyc_count   = cyc_q;
    assign o_instr_count = instr_q;
`else
    assign o_cyc_count   = 16'h0000;
    assign o_instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table plus hand sequences for pipe_ctrl.
// Counter checks follow the PIPE_CTRL_PERF_EN build option.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [4:0]  aluop;
    logic        memop;
    logic        shldbranch;
    logic        mem_ready;
    logic        halt;
    logic [6:0]  st;
    logic        fetch_en, decode_en, regread_en, alu_en, mem_en, regwrite_en;
    logic        pc_inc, pc_load;
    logic [15:0] cyc_count, instr_count;

    int checks = 0;
    int errors = 0;

    pipe_ctrl dut (
        .I_clk         (clk),
        .I_rst         (rst),
        .I_en          (en),
        .I_aluop       (aluop),
        .I_memop       (memop),
        .I_shldbranch  (shldbranch),
        .I_mem_ready   (mem_ready),
        .I_halt        (halt),
        .o_state       (st),
        .o_fetch_en    (fetch_en),
        .o_decode_en   (decode_en),
        .o_regread_en  (regread_en),
        .o_alu_en      (alu_en),
        .o_mem_en      (mem_en),
        .o_regwrite_en (regwrite_en),
        .o_pc_inc      (pc_inc),
        .o_pc_load     (pc_load),
        .o_cyc_count   (cyc_count),
        .o_instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       memop;
        logic       rdy;
        logic       halt;
        logic       br;
        logic [4:0] aluop;
        logic [6:0] st;
        logic [7:0] fl;
    } vec_t;

    // flags: {fetch, decode, regread, alu, mem, regwrite, pc_inc, pc_load}
    localparam logic [7:0] F_NONE = 8'b0000_0000;
    localparam logic [7:0] F_FET  = 8'b1000_1000;
    localparam logic [7:0] F_DEC  = 8'b0100_0000;
    localparam logic [7:0] F_RR   = 8'b0010_0000;
    localparam logic [7:0] F_EX   = 8'b0001_0000;
    localparam logic [7:0] F_MEM  = 8'b0000_1000;
    localparam logic [7:0] F_WBI  = 8'b0000_0110;
    localparam logic [7:0] F_WBL  = 8'b0000_0001;
    localparam logic [7:0] F_WBN  = 8'b0000_0010;

    vec_t vq[$];

    function automatic logic [7:0] flags();
        return {fetch_en, decode_en, regread_en, alu_en,
                mem_en, regwrite_en, pc_inc, pc_load};
    endfunction

    task automatic add(input logic e, input logic m, input logic r,
                       input logic h, input logic b, input logic [4:0] op,
                       input logic [6:0] s, input logic [7:0] f);
        vec_t v;
        v.en = e; v.memop = m; v.rdy = r; v.halt = h; v.br = b;
        v.aluop = op; v.st = s; v.fl = f;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; aluop = 5'd0; memop = 1'b0;
        shldbranch = 1'b0; mem_ready = 1'b0; halt = 1'b0;

        // plain ALU instruction
        add(1,0,1,0,0,5'b00000, 7'h01, F_NONE);
        add(1,0,1,0,0,5'b00000, 7'h02, F_FET);
        add(1,0,1,0,0,5'b00000, 7'h04, F_DEC);
        add(1,0,1,0,0,5'b00000, 7'h08, F_RR);
        add(1,0,1,0,0,5'b00000, 7'h10, F_EX);
        add(1,0,1,0,0,5'b00000, 7'h40, F_WBI);
        // memory instruction with fetch wait and 3 MEM wait cycles
        add(1,1,0,0,0,5'b00000, 7'h02, F_FET);
        add(1,1,1,0,0,5'b00000, 7'h02, F_FET);
        add(1,1,1,0,0,5'b00000, 7'h04, F_DEC);
        add(1,1,1,0,0,5'b00000, 7'h08, F_RR);
        add(1,1,1,0,0,5'b00000, 7'h10, F_EX);
        add(1,1,0,0,0,5'b00000, 7'h20, F_MEM);
        add(1,1,0,0,0,5'b00000, 7'h20, F_MEM);
        add(1,1,0,0,0,5'b00000, 7'h20, F_MEM);
        add(1,1,1,0,0,5'b00000, 7'h20, F_MEM);
        add(1,0,1,0,0,5'b00000, 7'h40, F_WBI);
        // JMPA taken, stall in EXEC and WB, halt ignored in REGREAD
        add(1,0,1,0,0,5'b11000, 7'h02, F_FET);
        add(1,0,1,0,0,5'b11000, 7'h04, F_DEC);
        add(1,0,1,1,0,5'b11000, 7'h08, F_RR);
        add(0,0,1,0,1,5'b11000, 7'h10, F_NONE);
        add(0,0,1,0,1,5'b11000, 7'h10, F_NONE);
        add(1,0,1,0,1,5'b11000, 7'h10, F_EX);
        add(0,0,1,1,0,5'b11000, 7'h40, F_NONE);
        add(1,0,1,0,0,5'b11000, 7'h40, F_WBL);
        // JMPR not taken, stall beats mem_ready, halt in WB
        add(0,0,1,0,0,5'b11010, 7'h02, F_NONE);
        add(1,0,1,0,0,5'b11010, 7'h02, F_FET);
        add(1,0,1,0,0,5'b11010, 7'h04, F_DEC);
        add(1,0,1,0,0,5'b11010, 7'h08, F_RR);
        add(1,0,1,0,0,5'b11010, 7'h10, F_EX);
        add(1,0,1,1,0,5'b11010, 7'h40, F_WBN);
        add(1,0,1,0,0,5'b00000, 7'h00, F_NONE);
        add(1,0,1,1,0,5'b00000, 7'h00, F_NONE);

        repeat (2) @(negedge clk);
        chk("reset_state", {9'd0, st}, 16'h0001);
        chk("reset_flags", {8'd0, flags()}, 16'h0000);
        chk("reset_cyc", cyc_count, 16'h0000);
        chk("reset_instr", instr_count, 16'h0000);
        rst = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk);
            en = vq[i].en; memop = vq[i].memop; mem_ready = vq[i].rdy;
            halt = vq[i].halt; shldbranch = vq[i].br; aluop = vq[i].aluop;
            #1;
            chk($sformatf("vec%0d_state", i), {9'd0, st}, {9'd0, vq[i].st});
            chk($sformatf("vec%0d_flags", i), {8'd0, flags()}, {8'd0, vq[i].fl});
        end

        // async reset out of HALT, then FETCH on next edge
        en = 1'b1; halt = 1'b0; memop = 1'b0; mem_ready = 1'b1;
        aluop = 5'd0; shldbranch = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("halt_rst_state", {9'd0, st}, 16'h0001);
        chk("halt_rst_flags", {8'd0, flags()}, 16'h0000);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        chk("rst_to_fetch", {9'd0, st}, 16'h0002);

        // async reset mid-instruction (EXEC)
        repeat (3) @(posedge clk);
        #1 chk("pre_rst_exec", {9'd0, st}, 16'h0010);
        #1 rst = 1'b1;
        #1;
        chk("exec_rst_state", {9'd0, st}, 16'h0001);
        chk("exec_rst_alu", {15'd0, alu_en}, 16'h0000);

        // three back-to-back non-memory instructions from reset
        @(negedge clk) rst = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("perf_state", {9'd0, st}, 16'h0002);
`ifdef PIPE_CTRL_PERF_EN
        chk("instr_count_3", instr_count, 16'd3);
        chk("cyc_count_15", cyc_count, 16'd15);
        repeat (4) @(posedge clk);
        #1 chk("wrap_in_wb", {9'd0, st}, 16'h0040);
        force dut.cyc_q = 16'hFFFF;
        force dut.instr_q = 16'hFFFF;
        #1;
        release dut.cyc_q;
        release dut.instr_q;
        @(posedge clk) #1;
        chk("cyc_wrap", cyc_count, 16'h0000);
        chk("instr_wrap", instr_count, 16'h0000);
`else
        chk("instr_count_off", instr_count, 16'h0000);
        chk("cyc_count_off", cyc_count, 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
